// File: rtl/transposed_fir_prog.sv
// Transposed-form (broadcast-input) FIR with a runtime-loadable, atomically swapped coefficient bank.
// Optional feature macro FIR_ROUND_SAT_EN: round-half-up plus saturation when narrowing to OUT_W.

module transposed_fir_prog #(
  parameter int TAPS       = 16,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int OUT_W      = 24,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  data_out,
  input  logic                     coef_load_valid,
  output logic                     coef_load_ready,
  input  logic signed [COEF_W-1:0] coef_load_data,
  input  logic                     coef_load_last,
  output logic                     coef_busy,
  output logic                     coef_err
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = $clog2(TAPS);
  // One bit of headroom over both the accumulator and the output so rounding cannot overflow.
  localparam int NARW_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [NARW_W-1:0] RND =
    (FRAC_SHIFT > 0) ? (NARW_W'(1) << ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0)) : '0;
  localparam logic signed [NARW_W-1:0] OUT_MAX = (NARW_W'(1) << (OUT_W - 1)) - NARW_W'(1);
  localparam logic signed [NARW_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWAP
  } coef_state_e;

  typedef logic signed [COEF_W-1:0] coef_bank_t [TAPS];

  // ---------------------------------------------------------------------------
  // Coefficient loader: shadow bank filled serially, copied to active bank in SWAP
  // ---------------------------------------------------------------------------
  coef_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  coef_bank_t       c_q, c_d;
  coef_bank_t       s_q, s_d;
  logic             err_q, err_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    state_d         = state_q;
    idx_d           = idx_q;
    c_d             = c_q;
    s_d             = s_q;
    err_d           = err_q;
    coef_load_ready = 1'b0;
    coef_busy       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        coef_load_ready = 1'b1;
        if (coef_load_valid) begin
          s_d[0]  = coef_load_data;
          idx_d   = IDX_W'(1);
          err_d   = 1'b0;
          state_d = ST_LOAD;
          if (coef_load_last) begin
            err_d   = 1'b1;
            s_d     = '{default: '0};
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_LOAD: begin
        coef_load_ready = 1'b1;
        coef_busy       = 1'b1;
        if (coef_load_valid) begin
          s_d[idx_q] = coef_load_data;
          idx_d      = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(TAPS - 1)) begin
            idx_d = '0;
            if (coef_load_last) begin
              state_d = ST_SWAP;
            end else begin
              err_d   = 1'b1;
              s_d     = '{default: '0};
              state_d = ST_IDLE;
            end
          end else if (coef_load_last) begin
            err_d   = 1'b1;
            s_d     = '{default: '0};
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_SWAP: begin
        coef_busy = 1'b1;
        c_d       = s_q;
        idx_d     = '0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: both banks are small register arrays (not RAM), so clearing them on reset is cheap
      // and guarantees the filter outputs zero until the first load completes.
      state_q <= ST_IDLE;
      idx_q   <= '0;
      c_q     <= '{default: '0};
      s_q     <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      s_q     <= s_d;
      err_q   <= err_d;
    end
  end

  assign coef_err = err_q;

  // ---------------------------------------------------------------------------
  // Datapath: broadcast multiply, registered adder chain, narrowing
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] m_q [TAPS];
  logic signed [PROD_W-1:0] m_d [TAPS];
  logic signed [ACC_W-1:0]  a_q [TAPS];
  logic signed [ACC_W-1:0]  a_d [TAPS];
  logic signed [NARW_W-1:0] sum_ext;
  logic signed [NARW_W-1:0] sum_shr;
  logic signed [OUT_W-1:0]  y_d;
  logic signed [OUT_W-1:0]  data_out_q;
  logic                     out_valid_q;

  always_comb begin
    // Tap i is reversed so that c[0] ends up weighting the newest sample at the chain output.
    for (int i = 0; i < TAPS; i++) begin
      m_d[i] = PROD_W'(c_q[TAPS-1-i]) * PROD_W'(data_in);
    end
    a_d[0] = ACC_W'(m_q[0]);
    for (int i = 1; i < TAPS; i++) begin
      a_d[i] = a_q[i-1] + ACC_W'(m_q[i]);
    end
  end

  always_comb begin
    sum_ext = NARW_W'(a_q[TAPS-1]);
`ifdef FIR_ROUND_SAT_EN
    sum_ext = sum_ext + RND;
`endif
    sum_shr = sum_ext >>> FRAC_SHIFT;
`ifdef FIR_ROUND_SAT_EN
    if (sum_shr > OUT_MAX) begin
      y_d = OUT_W'(OUT_MAX);
    end else if (sum_shr < OUT_MIN) begin
      y_d = OUT_W'(OUT_MIN);
    end else begin
      y_d = OUT_W'(sum_shr);
    end
`else
    y_d = OUT_W'(sum_shr);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q         <= '{default: '0};
      a_q         <= '{default: '0};
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        m_q        <= m_d;
        a_q        <= a_d;
        data_out_q <= y_d;
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule
